mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the core's load/store request interface. Accepts one
//   word-aligned request at a time over a valid/ready channel and performs a
//   byte-masked write or a full-word read on an internal word array. After a
//   programmable wait it returns the result on a valid/ready response channel.
//   The requester does sign/zero extension and lane selection; this block does not.
// PARAMETERS
//   DATA_WIDTH  32            data word width; fixed at 32, with 4 byte lanes
//   ADDR_WIDTH  32            byte address width
//   DEPTH_LOG2  10            log2 of the number of words in the array
//   BASE_ADDR   32'h80000000  byte address of word 0
//   LATENCY     2             wait cycles between accept and memory access, 0..15
// PORTS
//   clk         in   1   clock; all logic is on the rising edge
//   rst         in   1   synchronous, active-low reset
//   req_valid   in   1   request present
//   req_ready   out  1   block can accept a request
//   req_addr    in   32  byte address; bits [1:0] are ignored
//   req_wen     in   1   1 = write, 0 = read
//   req_wdata   in   32  write data, already placed in its byte lanes
//   req_wmask   in   4   byte-lane write enables; 4'h0 with wen=1 is a no-op write
//   resp_valid  out  1   response present
//   resp_ready  in   1   requester takes the response
//   resp_rdata  out  32  read data; 0 for writes and errors
//   resp_err    out  1   address is outside the array
// BEHAVIOUR
//   Reset (rst==0 at a rising edge):
//     - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
//     - Array contents are not reset.
//   IDLE:
//     - req_ready=1.
//     - On req_valid&&req_ready, latch addr, wen, wdata and wmask, then set req_ready=0.
//     - Next state: WAIT with counter=LATENCY if LATENCY>0, otherwise ACCESS.
//   WAIT:
//     - Decrement the counter each cycle.
//     - Go to ACCESS on the edge where the counter reaches 1.
//   ACCESS (exactly one cycle):
//     - Compute off = latched_addr - BASE_ADDR, modulo 2^32.
//     - In range: off < 4*2^DEPTH_LOG2. Word index = off[DEPTH_LOG2+1:2].
//     - Write, in range: update only the lanes where wmask[i]=1. Set rdata=0, err=0.
//     - Read, in range: rdata = the current array word. Set err=0.
//     - Out of range: no array update, rdata=0, err=1. Addresses below BASE wrap to a huge
//       offset and are out of range.
//     - Next state: RESP with resp_valid=1.
//   RESP:
//     - resp_valid, resp_rdata and resp_err stay stable until resp_valid&&resp_ready.
//     - On that handshake edge: resp_valid=0, rdata=0, err=0, next state IDLE.
//   Latency:
//     - Accept edge to resp_valid high is LATENCY+1 cycles when resp_ready is held high.
//     - A response taken at edge t gives req_ready=1 after edge t. The next request can be
//       accepted at edge t+1. No same-edge back-to-back transfers.
//   Hazards and edge cases:
//     - A read after a write to the same word returns the new data, because writes commit
//       in ACCESS before any later access.
//     - req_* inputs are ignored outside IDLE; latched values are unaffected by them.
//     - Reset mid-transaction: the state returns to IDLE.
//       - A write still in WAIT is dropped.
//       - A write already committed in ACCESS stays in the array.
//       - A pending response is discarded.
//   States: IDLE, WAIT, ACCESS, RESP, encoded in 2 bits.
//   Illegal encodings cannot occur.
// TESTING
//   1. LATENCY=2, BASE=0x80000000.
//      - Write addr 0x80000010, wdata 0xDEADBEEF, mask 4'hF.
//        -> resp_valid 3 cycles after accept, err=0, rdata=0.
//      - Then read 0x80000010 -> rdata 0xDEADBEEF.
//   2. Partial write after test 1: write 0x80000010, wdata 0x0000AB00, mask 4'h2.
//      - Then read -> 0xDEADABEF.
//   3. Read 0x80001000 (first out-of-range word for DEPTH_LOG2=10) -> err=1, rdata=0.
//      - Read 0x7FFFFFFC -> err=1.
//      - An out-of-range write leaves word 0 unchanged.
//   4. Hold resp_ready=0 for 5 cycles in RESP -> resp_* stable, req_ready=0.
//      - A new req_valid during this time is not accepted.
//      - Raise resp_ready -> req_ready=1 on the next cycle.
//   5. LATENCY=0: accept at edge t -> resp_valid high after edge t+1.
//      - With resp_ready and req_valid held high, accepts occur every 3 cycles.
//   6. Reset in WAIT during a write of 0x12345678 to word 4 -> IDLE, resp_valid=0.
//      - A following read of word 4 returns the old value.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: one load/store request at a time, byte-masked writes,
// full-word reads, and a programmable wait before the response is returned.
module mem_responder #(
    parameter int unsigned               DATA_WIDTH = 32,
    parameter int unsigned               ADDR_WIDTH = 32,
    parameter int unsigned               DEPTH_LOG2 = 10,
    parameter logic [ADDR_WIDTH-1:0]     BASE_ADDR  = 32'h8000_0000,
    parameter int unsigned               LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wen,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wmask,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err
);

    localparam int unsigned Lanes = DATA_WIDTH / 8;

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_e;

    state_e                  state_q;
    logic [3:0]              cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    wen_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [Lanes-1:0]        wmask_q;

    logic [DATA_WIDTH-1:0]   mem [2**DEPTH_LOG2];

    logic [ADDR_WIDTH-1:0]   off;
    logic                    in_range;
    logic [DEPTH_LOG2-1:0]   widx;
    logic                    mem_we;
    logic                    unused_off_bits;

    // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
    always_comb begin
        off      = addr_q - BASE_ADDR;
        in_range = (off[ADDR_WIDTH-1:DEPTH_LOG2+2] == '0);
        widx     = off[DEPTH_LOG2+1:2];
        mem_we   = rst && (state_q == StAccess) && wen_q && in_range;
    end

    assign unused_off_bits = ^off[1:0];

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < int'(Lanes); i++) begin
                if (wmask_q[i]) begin
                    mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        wen_q     <= req_wen;
                        wdata_q   <= req_wdata;
                        wmask_q   <= req_wmask;
                        req_ready <= 1'b0;
                        if (LATENCY > 0) begin
                            state_q <= StWait;
                            cnt_q   <= 4'(LATENCY);
                        end else begin
                            state_q <= StAccess;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    resp_valid <= 1'b1;
                    resp_err   <= !in_range;
                    resp_rdata <= (in_range && !wen_q) ? mem[widx] : '0;
                    state_q    <= StResp;
                end
                StResp: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a word-array reference model.
module tb_mem_responder;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          NWORDS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready, req_wen, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_wmask;

    logic        req_valid_z, req_ready_z, req_wen_z, resp_valid_z, resp_ready_z, resp_err_z;
    logic [31:0] req_addr_z, req_wdata_z, resp_rdata_z;
    logic [3:0]  req_wmask_z;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model [int];

    mem_responder #(.LATENCY(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .req_wmask  (req_wmask),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    mem_responder #(.LATENCY(0)) dut_z (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_z),
        .req_ready  (req_ready_z),
        .req_addr   (req_addr_z),
        .req_wen    (req_wen_z),
        .req_wdata  (req_wdata_z),
        .req_wmask  (req_wmask_z),
        .resp_valid (resp_valid_z),
        .resp_ready (resp_ready_z),
        .resp_rdata (resp_rdata_z),
        .resp_err   (resp_err_z)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] mask);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

    function automatic bit in_range(input logic [31:0] addr);
        logic [31:0] off = addr - BASE;
        return off < 32'(4 * NWORDS);
    endfunction

    // Full transaction on the LATENCY=2 instance with resp_ready held high.
    task automatic txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                       input logic [3:0] wmask, output logic [31:0] rdata, output logic err,
                       output int lat);
        req_addr = addr; req_wen = wen; req_wdata = wdata; req_wmask = wmask;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = resp_rdata; err = resp_err;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({req_ready, resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b err=%b rdata=%h, want 1 0 0 0",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        n_tests++;
        if ({req_ready_z, resp_valid_z, resp_err_z, resp_rdata_z} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_state_lat0: got rdy=%b vld=%b err=%b rdata=%h, want 1 0 0 0",
                     req_ready_z, resp_valid_z, resp_err_z, resp_rdata_z);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er; int lat;
        txn(BASE + 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        model[4] = 32'hDEAD_BEEF;
        n_tests++;
        if (lat != 3) begin
            n_fail++; $display("FAIL write_latency: got %0d, want 3", lat);
        end
        n_tests++;
        if ({er, rd} !== 33'h0) begin
            n_fail++; $display("FAIL write_resp: got err=%b rdata=%h, want 0 0", er, rd);
        end
        txn(BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if ({er, rd} !== {1'b0, 32'hDEAD_BEEF} || lat != 3) begin
            n_fail++;
            $display("FAIL read_back: got err=%b rdata=%h lat=%0d, want 0 deadbeef 3", er, rd, lat);
        end
    endtask

    task automatic test_partial_write();
        logic [31:0] rd; logic er; int lat;
        txn(BASE + 32'h10, 1'b1, 32'h0000_AB00, 4'h2, rd, er, lat);
        model[4] = merge(model[4], 32'h0000_AB00, 4'h2);
        txn(BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if ({er, rd} !== {1'b0, 32'hDEAD_ABEF}) begin
            n_fail++; $display("FAIL partial_write: got err=%b rdata=%h, want 0 deadabef", er, rd);
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd; logic er; int lat;
        txn(BASE, 1'b1, 32'h1111_1111, 4'hF, rd, er, lat);
        model[0] = 32'h1111_1111;
        txn(BASE + 32'h1000, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL oor_read_top: got err=%b rdata=%h, want 1 0", er, rd);
        end
        txn(32'h7FFF_FFFC, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if (er !== 1'b1) begin
            n_fail++; $display("FAIL oor_read_below: got err=%b, want 1", er);
        end
        txn(BASE + 32'h1000, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        n_tests++;
        if ({er, rd} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL oor_write: got err=%b rdata=%h, want 1 0", er, rd);
        end
        txn(BASE, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if ({er, rd} !== {1'b0, model[0]}) begin
            n_fail++; $display("FAIL oor_word0_kept: got err=%b rdata=%h, want 0 %h", er, rd, model[0]);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat;
        txn(BASE + 32'h14, 1'b1, 32'h55AA_55AA, 4'hF, rd, er, lat);
        model[5] = 32'h55AA_55AA;
        req_addr = BASE + 32'h10; req_wen = 1'b0; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        n_tests++;
        if (lat != 3) begin
            n_fail++; $display("FAIL stall_latency: got %0d, want 3", lat);
        end
        // Competing request while the response is stalled must be ignored.
        req_addr = BASE + 32'h14; req_wen = 1'b1; req_wdata = 32'h0; req_wmask = 4'hF;
        req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_tests++;
            if ({resp_valid, resp_err, resp_rdata, req_ready} !== {1'b1, 1'b0, model[4], 1'b0}) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got vld=%b err=%b rdata=%h rdy=%b, want 1 0 %h 0",
                         c, resp_valid, resp_err, resp_rdata, req_ready, model[4]);
            end
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL stall_release: got rdy=%b vld=%b, want 1 0", req_ready, resp_valid);
        end
        txn(BASE + 32'h14, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if ({er, rd} !== {1'b0, model[5]}) begin
            n_fail++; $display("FAIL stall_ignored_req: got err=%b rdata=%h, want 0 %h", er, rd, model[5]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        req_addr = BASE + 32'h10; req_wen = 1'b1; req_wdata = 32'h1234_5678; req_wmask = 4'hF;
        req_valid = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_tests++;
        if ({req_ready, resp_valid} !== 2'b10) begin
            n_fail++; $display("FAIL reset_mid_state: got rdy=%b vld=%b, want 1 0", req_ready, resp_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_noresp: got vld=%b, want 0", resp_valid);
        end
        txn(BASE + 32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_tests++;
        if ({er, rd} !== {1'b0, model[4]}) begin
            n_fail++; $display("FAIL reset_mid_dropped: got err=%b rdata=%h, want 0 %h", er, rd, model[4]);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, data, exp_rd;
        logic [31:0] oor [4];
        logic [3:0]  mask;
        logic        er, wen, exp_er;
        int          lat, idx;
        oor[0] = BASE + 32'h1000; oor[1] = BASE - 32'h4; oor[2] = 32'h0; oor[3] = 32'hFFFF_FFFC;
        for (int i = 0; i < 16; i++) begin
            data = $urandom;
            txn(BASE + 32'(4 * i), 1'b1, data, 4'hF, rd, er, lat);
            model[i] = data;
        end
        for (int n = 0; n < 50; n++) begin
            if ($urandom_range(0, 9) == 0) addr = oor[$urandom_range(0, 3)];
            else addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            wen = 1'($urandom_range(0, 1)); data = $urandom; mask = 4'($urandom_range(0, 15));
            idx = int'((addr - BASE) >> 2);
            exp_er = !in_range(addr);
            exp_rd = 32'h0;
            if (in_range(addr)) begin
                if (wen) model[idx] = merge(model[idx], data, mask);
                else exp_rd = model[idx];
            end
            txn(addr, wen, data, mask, rd, er, lat);
            n_tests++;
            if ({er, rd} !== {exp_er, exp_rd} || lat != 3) begin
                n_fail++;
                $display("FAIL random[%0d] addr=%h wen=%b: got err=%b rdata=%h lat=%0d, want %b %h 3",
                         n, addr, wen, er, rd, lat, exp_er, exp_rd);
            end
        end
    endtask

    task automatic test_latency0();
        req_addr_z = BASE; req_wen_z = 1'b1; req_wdata_z = 32'hFFFF_FFFF; req_wmask_z = 4'h0;
        req_valid_z = 1'b1; resp_ready_z = 1'b1;
        // Sample k is taken just after the k-th edge; an accept happens every third edge.
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            n_tests++;
            if ({req_ready_z, resp_valid_z} !== {k % 3 == 0, k % 3 == 2} ||
                (resp_valid_z === 1'b1 && {resp_err_z, resp_rdata_z} !== 33'h0)) begin
                n_fail++;
                $display("FAIL lat0_cycle[%0d]: got rdy=%b vld=%b err=%b rdata=%h, want %b %b 0 0",
                         k, req_ready_z, resp_valid_z, resp_err_z, resp_rdata_z,
                         k % 3 == 0, k % 3 == 2);
            end
        end
        req_valid_z = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_wen = 1'b0; req_wdata = '0; req_wmask = '0;
        resp_ready = 1'b1;
        req_valid_z = 1'b0; req_addr_z = '0; req_wen_z = 1'b0; req_wdata_z = '0;
        req_wmask_z = '0; resp_ready_z = 1'b1;
        test_reset();
        test_write_read();
        test_partial_write();
        test_out_of_range();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_latency0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
